// File: rtl/random_arbiter_pkg.sv
// random_pkg: types and widths shared by the random-word arbiter, its
// interface and the round-robin picker.
package random_pkg;

  localparam int RAND_W = 64;  // width of one random word from the FIFO
  localparam int SEED_W = 63;  // width of the LFSR seed

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a request or a pending reseed
    ACK   = 2'd1,  // one-cycle grant, FIFO word being popped
    SEED  = 2'd2,  // holding set_seed for the slow LFSR domain
    FLUSH = 2'd3   // discarding words generated from the old seed
  } state_e;

  // Bits needed for a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/random_arbiter_if.sv
// random_arbiter_if: every non-clock signal of the arbiter, bundled so
// the requester side, the FIFO read side and the LFSR seed side travel
// together. 'slave' is the arbiter's view, 'master' the environment's.
interface random_arbiter_if #(
  parameter int NREQ = 4
);
  import random_pkg::*;

  // requester side
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   ack;
  logic [RAND_W-1:0] data_out;

  // seed control and status
  logic [SEED_W-1:0] seed_in;
  logic              seed_load;
  logic              busy;

  // random source: FIFO read side (first-word-fall-through)
  logic [RAND_W-1:0] rnd_data;
  logic              rnd_valid;
  logic              rnd_read_ack;

  // random source: LFSR seed inputs
  logic [SEED_W-1:0] seed_out;
  logic              set_seed_out;

  modport slave (
    input  req, seed_in, seed_load, rnd_data, rnd_valid,
    output ack, data_out, busy, rnd_read_ack, seed_out, set_seed_out
  );

  modport master (
    output req, seed_in, seed_load, rnd_data, rnd_valid,
    input  ack, data_out, busy, rnd_read_ack, seed_out, set_seed_out
  );

endinterface

// File: rtl/random_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first requester
// with req set, looking upward from rr_ptr+1 and wrapping, plus a flag
// that is high when any requester is asking.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
  output logic [$clog2(NREQ)-1:0] winner_o,
  output logic                    found_o
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int SUM_W = IDX_W + 1;  // holds rr_ptr + 1 + offset before wrap

  logic [2*NREQ-1:0] req_doubled;
  logic [NREQ-1:0]   req_rotated;    // bit k = requester (rr_ptr+1+k) mod NREQ
  logic [SUM_W-1:0]  idx_sum;

  // Rotate the request vector so bit 0 is the first candidate, then take
  // the lowest set bit and map its offset back to a requester index.
  // NOTE: every variable assigned in an always_comb gets a default at the
  // top of the block, so no path leaves it unassigned and no latch is built.
  always_comb begin
    winner_o    = '0;
    found_o     = 1'b0;
    idx_sum     = '0;
    req_doubled = {req_i, req_i};
    // ptr+1 wraps to 0 for a power-of-two NREQ, which is the right answer;
    // otherwise it stays below 2^IDX_W and the doubled vector covers it.
    req_rotated = NREQ'(req_doubled >> (rr_ptr_i + 1'b1));
    for (int k = 0; k < NREQ; k++) begin
      if (!found_o && req_rotated[k]) begin
        idx_sum = {1'b0, rr_ptr_i} + SUM_W'(k) + SUM_W'(1);
        if (idx_sum >= SUM_W'(NREQ)) begin
          idx_sum = idx_sum - SUM_W'(NREQ);
        end
        winner_o = idx_sum[IDX_W-1:0];
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/random_arbiter.sv
// random_arbiter: hands out words from the single 64-bit random FIFO to
// NREQ requesters in round-robin order, one word per two cycles, and
// sequences reseeding: hold set_seed for the slow LFSR clock, then pop and
// discard the words that were already queued from the old seed.
// The NREQ parameter must match the NREQ of the connected interface.
module random_arbiter #(
  parameter int NREQ        = 4,   // requesters, 2..8
  parameter int SEED_HOLD   = 4,   // set_seed_out high time, >= 2 LFSR clocks
  parameter int FLUSH_WORDS = 16   // stale words to discard after a reseed
) (
  input  logic            clk,
  input  logic            reset,
  random_arbiter_if.slave bus
);
  import random_pkg::*;

  localparam int IDX_W   = $clog2(NREQ);
  localparam int HOLD_W  = cnt_width(SEED_HOLD);
  localparam int FLUSH_W = cnt_width(FLUSH_WORDS);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SEED_HOLD - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(FLUSH_WORDS);
  // Pointer starts on the last requester so requester 0 wins first.
  localparam logic [IDX_W-1:0]   PTR_RESET  = IDX_W'(NREQ - 1);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [RAND_W-1:0]  data_q, data_d;
  logic               rd_q, rd_d;            // FIFO pop strobe
  logic               set_seed_q, set_seed_d;
  logic [SEED_W-1:0]  seed_out_q, seed_out_d;
  logic               busy_q, busy_d;
  logic               seed_pend_q, seed_pend_d;
  logic [SEED_W-1:0]  seed_reg_q, seed_reg_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_idx),
    .found_o  (pick_found)
  );

  // State register and all registered outputs, synchronous reset.
  // NOTE: sequential state is updated with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      data_q      <= '0;
      rd_q        <= 1'b0;
      set_seed_q  <= 1'b0;
      seed_out_q  <= '0;
      busy_q      <= 1'b0;
      seed_pend_q <= 1'b0;
      seed_reg_q  <= '0;
      rr_ptr_q    <= PTR_RESET;
      flush_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
      set_seed_q  <= set_seed_d;
      seed_out_q  <= seed_out_d;
      busy_q      <= busy_d;
      seed_pend_q <= seed_pend_d;
      seed_reg_q  <= seed_reg_d;
      rr_ptr_q    <= rr_ptr_d;
      flush_cnt_q <= flush_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Next state and next registered outputs. Strobes (ack, pop, set_seed)
  // default low; data_out, seed_out and the counters default to holding.
  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    data_d      = data_q;
    rd_d        = 1'b0;
    set_seed_d  = 1'b0;
    seed_out_d  = seed_out_q;
    seed_pend_d = seed_pend_q;
    seed_reg_d  = seed_reg_q;
    rr_ptr_d    = rr_ptr_q;
    flush_cnt_d = flush_cnt_q;
    hold_cnt_d  = hold_cnt_q;

    if (bus.seed_load) begin
      seed_reg_d = bus.seed_in;
    end

    case (state_q)
      IDLE: begin
        if (seed_pend_q) begin
          // A reseed outranks any request. A seed arriving in this very
          // cycle is the newest one, so it is used directly.
          state_d     = SEED;
          seed_pend_d = 1'b0;
          hold_cnt_d  = '0;
          flush_cnt_d = '0;
          set_seed_d  = 1'b1;
          seed_out_d  = bus.seed_load ? bus.seed_in : seed_reg_q;
        end else begin
          if (bus.seed_load) begin
            seed_pend_d = 1'b1;
          end
          if (pick_found && bus.rnd_valid) begin
            state_d  = ACK;
            data_d   = bus.rnd_data;
            ack_d    = NREQ'(1) << pick_idx;
            rd_d     = 1'b1;
            rr_ptr_d = pick_idx;
          end
        end
      end

      ACK: begin
        // The pop is in flight, so rnd_valid is stale here; never grant
        // back to back. A seed_load here waits one IDLE cycle.
        state_d = IDLE;
        if (bus.seed_load) begin
          seed_pend_d = 1'b1;
        end
      end

      SEED, FLUSH: begin
        if (bus.seed_load) begin
          // A newer seed restarts the whole hold-and-drain sequence.
          state_d     = SEED;
          seed_pend_d = 1'b0;
          hold_cnt_d  = '0;
          flush_cnt_d = '0;
          set_seed_d  = 1'b1;
          seed_out_d  = bus.seed_in;
        end else if (state_q == SEED) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            set_seed_d = 1'b1;
          end
        end else begin
          if (flush_cnt_q == FLUSH_DONE) begin
            state_d = IDLE;
          end else if (bus.rnd_valid && !rd_q) begin
            // Skip the cycle after a pop: valid still reflects the old word.
            rd_d        = 1'b1;
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SEED) || (state_d == FLUSH);
  end

  assign bus.ack          = ack_q;
  assign bus.data_out     = data_q;
  assign bus.rnd_read_ack = rd_q;
  assign bus.set_seed_out = set_seed_q;
  assign bus.seed_out     = seed_out_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_random_arbiter.sv
// tb_random_arbiter: directed stimulus for the round-robin random-word
// arbiter, checked every cycle against a behavioural model and pinned by
// hand-computed expectations for each scenario.
module tb_random_arbiter;
  import random_pkg::*;

  localparam int NREQ        = 4;
  localparam int SEED_HOLD   = 4;
  localparam int FLUSH_WORDS = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  random_arbiter_if #(.NREQ(NREQ)) bus ();

  random_arbiter #(
    .NREQ        (NREQ),
    .SEED_HOLD   (SEED_HOLD),
    .FLUSH_WORDS (FLUSH_WORDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: modes with remaining-cycle / remaining-word budgets
  // and a "last winner" for round robin. Variables describe the outputs
  // visible during the current cycle.
  // ---------------------------------------------------------------------
  typedef enum {M_IDLE, M_GRANT, M_SEEDING, M_DRAINING} mmode_e;

  mmode_e          m_mode;
  logic [NREQ-1:0] m_ack;
  logic [63:0]     m_data;
  logic            m_pop, m_set, m_busy, m_pend;
  logic [62:0]     m_seed_out, m_seed_reg;
  int              m_last, m_seed_left, m_discards_left, m_win, m_idx;
  bit              m_popped, m_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_IDLE;  m_ack = '0;  m_data = '0;  m_pop = 1'b0;
      m_set = 1'b0;  m_seed_out = '0;  m_busy = 1'b0;  m_pend = 1'b0;
      m_seed_reg = '0;  m_last = NREQ - 1;  m_seed_left = 0;
      m_discards_left = 0;  m_live = 1'b1;
    end else if (m_live) begin
      m_popped = m_pop;
      m_ack    = '0;
      m_pop    = 1'b0;
      m_set    = 1'b0;
      if (bus.seed_load && (m_mode == M_SEEDING || m_mode == M_DRAINING)) begin
        m_mode      = M_SEEDING;
        m_seed_left = SEED_HOLD;
        m_seed_out  = bus.seed_in;
        m_set       = 1'b1;
        m_pend      = 1'b0;
      end else begin
        case (m_mode)
          M_IDLE: begin
            if (m_pend) begin
              m_pend      = 1'b0;
              m_mode      = M_SEEDING;
              m_seed_left = SEED_HOLD;
              m_seed_out  = bus.seed_load ? bus.seed_in : m_seed_reg;
              m_set       = 1'b1;
            end else begin
              if (bus.seed_load) m_pend = 1'b1;
              m_win = -1;
              if (bus.rnd_valid) begin
                for (int k = 1; k <= NREQ; k++) begin
                  m_idx = (m_last + k) % NREQ;
                  if (m_win < 0 && ((bus.req >> m_idx) & 4'b0001) != 0) m_win = m_idx;
                end
              end
              if (m_win >= 0) begin
                m_ack  = NREQ'(1) << m_win;
                m_pop  = 1'b1;
                m_data = bus.rnd_data;
                m_last = m_win;
                m_mode = M_GRANT;
              end
            end
          end
          M_GRANT: begin
            m_mode = M_IDLE;
            if (bus.seed_load) m_pend = 1'b1;
          end
          M_SEEDING: begin
            if (m_seed_left == 1) begin
              m_mode          = M_DRAINING;
              m_discards_left = FLUSH_WORDS;
            end else begin
              m_seed_left--;
              m_set = 1'b1;
            end
          end
          M_DRAINING: begin
            if (m_discards_left == 0) begin
              m_mode = M_IDLE;
            end else if (bus.rnd_valid && !m_popped) begin
              m_pop = 1'b1;
              m_discards_left--;
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
      if (bus.seed_load) m_seed_reg = bus.seed_in;
      m_busy = (m_mode == M_SEEDING) || (m_mode == M_DRAINING);
    end
  end

  // ---------------------------------------------------------------------
  // Compare process plus running event totals used by the directed checks.
  // ---------------------------------------------------------------------
  bit prev_pop = 1'b0;
  int tot_pop = 0, tot_ack = 0, tot_set = 0, tot_set_1234 = 0, tot_set_55 = 0;
  int tot_busy_ack = 0;
  int ack_log[$];

  always @(negedge clk) begin
    if (m_live) begin
      check("ack",          64'(bus.ack),          64'(m_ack));
      check("data_out",     bus.data_out,          m_data);
      check("rnd_read_ack", 64'(bus.rnd_read_ack), 64'(m_pop));
      check("set_seed_out", 64'(bus.set_seed_out), 64'(m_set));
      check("seed_out",     64'(bus.seed_out),     64'(m_seed_out));
      check("busy",         64'(bus.busy),         64'(m_busy));
      check("pop_without_valid", 64'(bus.rnd_read_ack && !bus.rnd_valid), 64'(0));
      check("back_to_back_pop",  64'(bus.rnd_read_ack && prev_pop), 64'(0));
      prev_pop = bus.rnd_read_ack;
      if (bus.rnd_read_ack) tot_pop++;
      if (bus.set_seed_out) begin
        tot_set++;
        if (bus.seed_out == 63'h1234) tot_set_1234++;
        if (bus.seed_out == 63'h55)   tot_set_55++;
      end
      if (bus.ack != '0) begin
        tot_ack++;
        if (bus.busy) tot_busy_ack++;
        for (int k = 0; k < NREQ; k++) begin
          if (((bus.ack >> k) & 4'b0001) != 0) ack_log.push_back(k);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req       = '0;
    bus.seed_load = 1'b0;
    bus.seed_in   = '0;
    bus.rnd_valid = 1'b0;
    bus.rnd_data  = '0;
    tick(1);
    check("rst_ack",      64'(bus.ack),          64'(0));
    check("rst_data",     bus.data_out,          64'(0));
    check("rst_pop",      64'(bus.rnd_read_ack), 64'(0));
    check("rst_set_seed", 64'(bus.set_seed_out), 64'(0));
    check("rst_busy",     64'(bus.busy),         64'(0));
    reset = 1'b0;
  endtask

  int base_pop, base_ack, base_set, base_s1, base_s2, base_bsy, log_base, guard;
  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    do_reset();

    // Grant path: single requester, one-cycle latency, one pop.
    base_pop = tot_pop;  base_ack = tot_ack;
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 64'hA5A5_0000_0000_0001;
    bus.req       = 4'b0001;
    tick(1);
    check("t1_ack",  64'(bus.ack), 64'h1);
    check("t1_data", bus.data_out, 64'hA5A5_0000_0000_0001);
    tick(1);
    bus.req = '0;
    tick(2);
    check("t1_pops", 64'(tot_pop - base_pop), 64'd1);
    check("t1_acks", 64'(tot_ack - base_ack), 64'd1);

    // Fairness: all four requesting for 16 cycles.
    do_reset();
    base_pop = tot_pop;  base_ack = tot_ack;  log_base = ack_log.size();
    bus.rnd_valid = 1'b1;
    bus.req       = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      bus.rnd_data = {32'hF00D_0000, 32'(i)};
      tick(1);
    end
    bus.req = '0;
    tick(2);
    check("t2_acks", 64'(tot_ack - base_ack), 64'd8);
    check("t2_pops", 64'(tot_pop - base_pop), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (log_base + i < ack_log.size())
        check("t2_order", 64'(ack_log[log_base + i]), 64'(exp_order[i]));
      else
        check("t2_order_missing", 64'(i), 64'(8));
    end

    // Empty FIFO: request waits until valid rises.
    do_reset();
    base_pop = tot_pop;  base_ack = tot_ack;
    bus.req = 4'b0100;
    tick(10);
    check("t3_no_ack", 64'(tot_ack - base_ack), 64'd0);
    check("t3_no_pop", 64'(tot_pop - base_pop), 64'd0);
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 64'h0123_4567_89AB_CDEF;
    tick(1);
    check("t3_ack", 64'(bus.ack), 64'h4);
    tick(1);
    bus.req = '0;
    tick(2);
    check("t3_pops", 64'(tot_pop - base_pop), 64'd1);

    // Reseed with requesters waiting.
    do_reset();
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 64'hDEAD_BEEF_0000_0004;
    base_pop = tot_pop;  base_set = tot_set;  base_s1 = tot_set_1234;  base_bsy = tot_busy_ack;
    bus.seed_in   = 63'h1234;
    bus.seed_load = 1'b1;
    tick(1);
    bus.seed_load = 1'b0;
    bus.req       = 4'b0011;
    guard = 0;
    while (!bus.busy && guard < 10) begin tick(1); guard++; end
    check("t4_busy_rise_timeout", 64'(guard < 10), 64'd1);
    guard = 0;
    while (bus.busy && guard < 100) begin tick(1); guard++; end
    check("t4_busy_fall_timeout", 64'(guard < 100), 64'd1);
    check("t4_set_cycles",  64'(tot_set - base_set),      64'd4);
    check("t4_seed_value",  64'(tot_set_1234 - base_s1),  64'd4);
    check("t4_discards",    64'(tot_pop - base_pop),      64'd16);
    check("t4_ack_in_busy", 64'(tot_busy_ack - base_bsy), 64'd0);
    guard = 0;
    while (bus.ack == '0 && guard < 10) begin tick(1); guard++; end
    check("t4_ack_timeout", 64'(guard < 10), 64'd1);
    check("t4_first_ack", 64'(bus.ack), 64'h1);
    tick(1);
    bus.req = '0;
    tick(2);

    // Reseed restarted during FLUSH after five discards.
    do_reset();
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 64'h5555_AAAA_5555_AAAA;
    base_pop      = tot_pop;
    bus.seed_in   = 63'h1234;
    bus.seed_load = 1'b1;
    tick(1);
    bus.seed_load = 1'b0;
    guard = 0;
    while ((tot_pop - base_pop) < 5 && guard < 100) begin tick(1); guard++; end
    check("t5_five_discards_timeout", 64'(guard < 100), 64'd1);
    check("t5_busy_mid_flush", 64'(bus.busy), 64'd1);
    base_pop = tot_pop;  base_set = tot_set;  base_s2 = tot_set_55;
    bus.seed_in   = 63'h55;
    bus.seed_load = 1'b1;
    tick(1);
    bus.seed_load = 1'b0;
    guard = 0;
    while (bus.busy && guard < 100) begin tick(1); guard++; end
    check("t5_busy_fall_timeout", 64'(guard < 100), 64'd1);
    check("t5_set_cycles", 64'(tot_set - base_set),   64'd4);
    check("t5_seed_value", 64'(tot_set_55 - base_s2), 64'd4);
    check("t5_discards",   64'(tot_pop - base_pop),   64'd16);
    check("t5_seed_hold",  64'(bus.seed_out),         64'h55);

    // Reset asserted during an ACK cycle.
    do_reset();
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 64'hCAFE_F00D_1234_5678;
    bus.req       = 4'b1111;
    tick(1);
    check("t6_first_ack", 64'(bus.ack), 64'h1);
    tick(2);
    check("t6_second_ack", 64'(bus.ack), 64'h2);
    reset = 1'b1;
    tick(1);
    check("t6_rst_ack",      64'(bus.ack),          64'd0);
    check("t6_rst_data",     bus.data_out,          64'd0);
    check("t6_rst_pop",      64'(bus.rnd_read_ack), 64'd0);
    check("t6_rst_set_seed", 64'(bus.set_seed_out), 64'd0);
    check("t6_rst_seed_out", 64'(bus.seed_out),     64'd0);
    check("t6_rst_busy",     64'(bus.busy),         64'd0);
    reset = 1'b0;
    tick(1);
    check("t6_ack_after_reset", 64'(bus.ack), 64'h1);
    tick(1);
    bus.req = '0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/random_arbiter.md
Name: random_arbiter

Overview:
- Shares the single 64-bit random-number source (LFSR feeding a dual-clock FIFO) between NREQ requesters, e.g. DDS phase/amplitude dither channels.
- Arbitration is round-robin.
- Sequences reseeding: holds set_seed long enough for the slow LFSR domain to sample it, then discards the stale words already queued in the FIFO so no requester receives pre-seed data.
- Sits in the read-clock domain, between the random source's FIFO read side and the consumers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SEED_HOLD, 4, cycles set_seed_out stays high (at least 2 LFSR-clock periods).
- FLUSH_WORDS, 16, words popped and discarded after a reseed (at least FIFO depth plus LFSR pipeline).

Ports:
- clk  in  1  read-side clock (same as the FIFO read clock).
- reset  in  1  synchronous, active-high.
- req  in  NREQ  per-requester level request.
- ack  out  NREQ  one-hot, one-cycle pulse; data_out valid in that cycle.
- data_out  out  64  random word for the acked requester.
- seed_in  in  63  new seed.
- seed_load  in  1  one-cycle pulse; latches seed_in.
- busy  out  1  high while in SEED or FLUSH.
- rnd_data  in  64  FIFO dout (first-word-fall-through).
- rnd_valid  in  1  FIFO valid.
- rnd_read_ack  out  1  FIFO rd_en.
- seed_out  out  63  to LFSR seed.
- set_seed_out  out  1  to LFSR set_seed.

Behaviour:
- Reset values: state=IDLE, ack=0, data_out=0, rnd_read_ack=0, set_seed_out=0, seed_out=0, busy=0, seed_pend=0, rr_ptr=NREQ-1 (requester 0 wins first), flush_cnt=0, hold_cnt=0.
- seed_load in any state latches seed_in into seed_reg and sets seed_pend.
  - In SEED or FLUSH it restarts SEED with the new seed: hold_cnt and flush_cnt are cleared.
- States:
  - IDLE:
    - seed_pend has priority: go to SEED and clear seed_pend.
    - Otherwise, if |req and rnd_valid: the winner is the first set bit of req searching upward (with wrap) from rr_ptr+1. Then:
      - data_out<=rnd_data
      - ack<=onehot(winner)
      - rnd_read_ack<=1
      - rr_ptr<=winner
      - go to ACK.
    - Otherwise stay in IDLE and drive all outputs low except data_out, which holds its value.
  - ACK (1 cycle):
    - ack and rnd_read_ack are high during this cycle only, so the FIFO pops exactly one word.
    - Go to IDLE.
    - rnd_valid is ignored in this cycle because FIFO valid lags the pop.
    - Throughput is one word per 2 cycles; latency from req with rnd_valid to ack is 1 cycle.
  - SEED:
    - seed_out=seed_reg; set_seed_out=1 for exactly SEED_HOLD cycles (hold_cnt 0..SEED_HOLD-1).
    - Then go to FLUSH with flush_cnt=0.
  - FLUSH:
    - When rnd_valid is high and no pop was issued in the previous cycle: pulse rnd_read_ack and increment flush_cnt.
    - When flush_cnt reaches FLUSH_WORDS, go to IDLE.
    - ack stays 0 throughout.
    - There is no timeout: the FIFO refills continuously.
- Requester rule:
  - A requester wanting one word drops req on the clock edge that ends its ack cycle.
  - A req held high is served again, round-robin with the others.
- A requester deasserting req before it is granted is legal; no word is lost.
- A seed_load arriving in an ACK cycle does not cancel that ack; SEED starts after the following IDLE cycle.
- Only one rnd_read_ack pulse may occur per two cycles in any state; a pop is never issued while rnd_valid=0.
- seed_out holds its last value outside SEED.
- busy is registered and equals the state being SEED or FLUSH.

Decomposition:
- Shared package random_pkg holds:
  - state enum (IDLE, ACK, SEED, FLUSH)
  - RAND_W=64, SEED_W=63
- One sub-module is natural: rr_pick. It is combinational, maps req and rr_ptr to winner index plus any flag, and is parameterised by NREQ.

Test Plan:
- Grant path: reset, rnd_valid=1, rnd_data=64'hA5A5_0000_0000_0001, req=4'b0001 pulsed until ack → ack=0001 one cycle later, data_out=A5A5_0000_0000_0001, exactly one rnd_read_ack pulse.
- Fairness: req=4'b1111 held for 16 cycles, rnd_valid=1 → ack order 0,1,2,3,0,1,2,3 every other cycle; 8 acks and 8 pops.
- Empty FIFO: req=4'b0100, rnd_valid=0 for 10 cycles, then 1 → no ack and no rnd_read_ack until valid; ack=0100 one cycle after valid rises.
- Reseed: seed_load with seed_in=63'h1234 while req=4'b0011 held → set_seed_out high 4 cycles with seed_out=63'h1234, busy=1, then 16 discard pops with ack=0 throughout, then grants resume to requester 0.
- Reseed during FLUSH: second seed_load (63'h55) after 5 discards → SEED restarts with 4 cycles of set_seed_out at 63'h55, followed by a full 16 fresh discards.
- Reset mid-flight: assert reset in an ACK cycle → next cycle all outputs at reset values; first grant after reset goes to requester 0.
